// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: command encodings and FSM state type shared by cnt_ctrl and its bench.
package cnt_ctrl_pkg;
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_STOP   = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/cnt_ctrl_presc.sv
// cnt_ctrl_presc: divide-by-PRESC tick generator for cnt_ctrl.
// Ports: clk, rst (async active-high), en (advance phase), clr (restart phase), tick (phase wraps while en).
module cnt_ctrl_presc #(
    parameter int PRESC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(PRESC);
    localparam logic [W-1:0] LAST = W'(PRESC - 1);
    logic [W-1:0] q;
    assign tick = en && q == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= tick ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: command-driven up-counter with one-shot/periodic terminal count.
// Ports: clk, rst (async active-high); cmd_valid/cmd_ready/cmd_op/cmd_limit/cmd_periodic command
// channel; cnt, busy (RUN/HOLD), done (DONE), tc_pulse and err_pulse (registered strobes).
// Build option: define CNT_CTRL_PRESCALE_EN to tick once every PRESC clocks instead of every clock.
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRESC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse,
    output logic             err_pulse
);
    state_t state, nstate;
    logic [WIDTH-1:0] lim, nlim, ncnt;
    logic per, nper, ntc, nerr;
    logic acc, cmd_win, run_en, tick;
    assign cmd_ready = !rst;
    assign acc       = cmd_valid && cmd_ready;
    // Every accepted command except the illegal RESUME-in-RUN overrides the count for this cycle.
    assign cmd_win   = acc && !(state == RUN && cmd_op == OP_RESUME);
    assign run_en    = state == RUN && !cmd_win;
    assign busy      = state == RUN || state == HOLD;
    assign done      = state == DONE;
`ifdef CNT_CTRL_PRESCALE_EN
    cnt_ctrl_presc #(.PRESC(PRESC)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (acc && (cmd_op == OP_START || cmd_op == OP_STOP)),
        .tick (tick)
    );
`else
    assign tick = run_en;
`endif
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nlim   = lim;
        nper   = per;
        ntc    = 1'b0;
        nerr   = 1'b0;
        if (tick) begin
            if (cnt != lim) begin
                ncnt = cnt + 1'b1;
            end else begin
                ntc    = 1'b1;
                ncnt   = per ? '0 : lim;
                nstate = per ? RUN : DONE;
            end
        end
        if (acc) begin
            case (cmd_op)
                OP_START: begin
                    nstate = RUN;
                    ncnt   = '0;
                    nlim   = cmd_limit;
                    nper   = cmd_periodic;
                end
                OP_PAUSE: begin
                    nstate = state == RUN ? HOLD : state;
                    nerr   = state != RUN;
                end
                OP_RESUME: begin
                    nstate = state == HOLD ? RUN : state;
                    nerr   = state != HOLD;
                end
                default: begin
                    nstate = IDLE;
                    ncnt   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lim       <= '0;
            per       <= 1'b0;
            tc_pulse  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            lim       <= nlim;
            per       <= nper;
            tc_pulse  <= ntc;
            err_pulse <= nerr;
        end
    end
endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed scoreboard bench for cnt_ctrl.
module tb_cnt_ctrl;
    import cnt_ctrl_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_limit = 4'd0;
    logic       cmd_periodic = 1'b0;
    logic [3:0] cnt;
    logic       busy, done, tc_pulse, err_pulse;
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [8:0] exp_q[$];

    cnt_ctrl #(.WIDTH(4), .PRESC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_limit    (cmd_limit),
        .cmd_periodic (cmd_periodic),
        .cnt          (cnt),
        .busy         (busy),
        .done         (done),
        .tc_pulse     (tc_pulse),
        .err_pulse    (err_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record is pushed per clock edge; compare it half a cycle later.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e, g;
            e = exp_q.pop_front();
            g = {cnt, cmd_ready, busy, done, tc_pulse, err_pulse};
            checks++;
            step_no++;
            if (g !== e) begin
                errors++;
                $display("FAIL step%0d {cnt,rdy,busy,done,tc,err} got %h/%b expected %h/%b",
                         step_no, g[8:5], g[4:0], e[8:5], e[4:0]);
            end
        end
    end

    // Drive one clock of stimulus and queue the outputs expected right after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] lim, input logic per,
                        input logic [3:0] ec, input logic eb, input logic ed, input logic et,
                        input logic ee);
        cmd_valid = v;
        cmd_op = op;
        cmd_limit = lim;
        cmd_periodic = per;
        @(posedge clk);
        exp_q.push_back({ec, 1'b1, eb, ed, et, ee});
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] lim, input logic per,
                       input logic [3:0] ec, input logic eb, input logic ed, input logic et,
                       input logic ee);
        step(1'b1, op, lim, per, ec, eb, ed, et, ee);
    endtask

    task automatic idle(input logic [3:0] ec, input logic eb, input logic ed, input logic et);
        step(1'b0, OP_START, 4'd0, 1'b0, ec, eb, ed, et, 1'b0);
    endtask

    task automatic check_reset(input string name);
        logic [5:0] g;
        g = {cnt == 4'd0, cmd_ready, busy, done, tc_pulse, err_pulse};
        checks++;
        if (g !== 6'b100000) begin
            errors++;
            $display("FAIL %s {cnt0,rdy,busy,done,tc,err} got %b expected 100000", name, g);
        end
    endtask

    // Let the monitor consume the last record, then assert reset between clock edges.
    task automatic async_reset;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset("async_rst");
        @(posedge clk);
        #1 check_reset("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_reset("por");
        rst = 1'b0;
`ifndef CNT_CTRL_PRESCALE_EN
        // One-shot limit 5
        cmd(OP_START, 4'd5, 1'b0, 4'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) idle(4'(k), 1, 0, 0);
        idle(4'd5, 0, 1, 1);
        idle(4'd5, 0, 1, 0);
        idle(4'd5, 0, 1, 0);
        // Periodic limit 3, START from DONE
        cmd(OP_START, 4'd3, 1'b1, 4'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) idle(4'(k % 4), 1, 0, k % 4 == 0);
        // PAUSE at cnt=2, hold 10 clocks, RESUME
        idle(4'd1, 1, 0, 0);
        idle(4'd2, 1, 0, 0);
        cmd(OP_PAUSE, 4'd0, 1'b0, 4'd2, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) idle(4'd2, 1, 0, 0);
        cmd(OP_RESUME, 4'd0, 1'b0, 4'd2, 1, 0, 0, 0);
        idle(4'd3, 1, 0, 0);
        idle(4'd0, 1, 0, 1);
        // Illegal commands: PAUSE in IDLE, RESUME in RUN
        cmd(OP_STOP, 4'd0, 1'b0, 4'd0, 0, 0, 0, 0);
        cmd(OP_PAUSE, 4'd0, 1'b0, 4'd0, 0, 0, 0, 1);
        idle(4'd0, 0, 0, 0);
        cmd(OP_START, 4'd7, 1'b0, 4'd0, 1, 0, 0, 0);
        cmd(OP_RESUME, 4'd0, 1'b0, 4'd1, 1, 0, 0, 1);
        idle(4'd2, 1, 0, 0);
        // STOP on the terminal tick
        cmd(OP_START, 4'd2, 1'b0, 4'd0, 1, 0, 0, 0);
        idle(4'd1, 1, 0, 0);
        idle(4'd2, 1, 0, 0);
        cmd(OP_STOP, 4'd0, 1'b0, 4'd0, 0, 0, 0, 0);
        idle(4'd0, 0, 0, 0);
        // limit 0 periodic: tc on every tick
        cmd(OP_START, 4'd0, 1'b1, 4'd0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) idle(4'd0, 1, 0, 1);
        // Full range one-shot
        cmd(OP_START, 4'd15, 1'b0, 4'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 15; k++) idle(4'(k), 1, 0, 0);
        idle(4'd15, 0, 1, 1);
        // PAUSE and START on the terminal tick
        cmd(OP_START, 4'd1, 1'b1, 4'd0, 1, 0, 0, 0);
        idle(4'd1, 1, 0, 0);
        cmd(OP_PAUSE, 4'd0, 1'b0, 4'd1, 1, 0, 0, 0);
        cmd(OP_RESUME, 4'd0, 1'b0, 4'd1, 1, 0, 0, 0);
        idle(4'd0, 1, 0, 1);
        idle(4'd1, 1, 0, 0);
        cmd(OP_START, 4'd1, 1'b0, 4'd0, 1, 0, 0, 0);
        idle(4'd1, 1, 0, 0);
        // Async reset while cnt sits at its terminal value
        async_reset();
        cmd(OP_START, 4'd2, 1'b1, 4'd0, 1, 0, 0, 0);
        idle(4'd1, 1, 0, 0);
`else
        // Prescale by 4, periodic limit 3
        cmd(OP_START, 4'd3, 1'b1, 4'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) idle(4'((k / 4) % 4), 1, 0, k == 16);
        idle(4'd0, 1, 0, 0);
        idle(4'd0, 1, 0, 0);
        async_reset();
        // Fresh START after reset, then phase kept across PAUSE/RESUME
        cmd(OP_START, 4'd5, 1'b0, 4'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) idle(4'(k / 4), 1, 0, 0);
        idle(4'd2, 1, 0, 0);
        idle(4'd2, 1, 0, 0);
        cmd(OP_PAUSE, 4'd0, 1'b0, 4'd2, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) idle(4'd2, 1, 0, 0);
        cmd(OP_RESUME, 4'd0, 1'b0, 4'd2, 1, 0, 0, 0);
        idle(4'd2, 1, 0, 0);
        idle(4'd3, 1, 0, 0);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, 4, counter and limit width in bits.
REQ-003 Parameter: PRESC, 4, prescaler divide ratio (used only with CNT_CTRL_PRESCALE_EN, legal 2..256).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: cmd_valid  input  1  command present.
REQ-007 Port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 Port: cmd_op  input  2  00 START, 01 PAUSE, 10 RESUME, 11 STOP.
REQ-009 Port: cmd_limit  input  WIDTH  terminal value, sampled on START only.
REQ-010 Port: cmd_periodic  input  1  1 = periodic, 0 = one-shot, sampled on START only.
REQ-011 Port: cnt  output  WIDTH  current count.
REQ-012 Port: busy  output  1  high in RUN or HOLD.
REQ-013 Port: done  output  1  high in DONE.
REQ-014 Port: tc_pulse  output  1  one-cycle terminal-count strobe.
REQ-015 Port: err_pulse  output  1  one-cycle strobe on an accepted illegal command.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-017 cmd_ready SHALL be 1 in every state except while rst is high.
REQ-018 START SHALL be legal in every state: latch limit and mode, set cnt=0, clear prescaler, go to RUN on the next edge.
REQ-019 PAUSE SHALL be legal only in RUN (go to HOLD, freeze cnt); RESUME SHALL be legal only in HOLD (go to RUN).
REQ-020 STOP SHALL be legal in every state: go to IDLE, cnt=0.
REQ-021 An illegal command SHALL be consumed with no state change and SHALL assert err_pulse for exactly one cycle.
REQ-022 In RUN, each tick SHALL do the following: if cnt!=limit then cnt=cnt+1; else assert tc_pulse in the same cycle and set cnt=0 (periodic, stay in RUN) or hold cnt=limit and go to DONE (one-shot).
REQ-023 limit=0 SHALL give tc_pulse on every tick; limit=2^WIDTH-1 SHALL count the full range with no overflow wrap other than REQ-022.
REQ-024 tc_pulse and err_pulse SHALL be registered outputs.
REQ-025 Simultaneous command and terminal tick: the command SHALL win, and tc_pulse SHALL be suppressed for STOP, PAUSE and START.
REQ-026 DONE SHALL persist until START or STOP.
REQ-027 In HOLD, IDLE and DONE, cnt and the prescaler SHALL NOT change.

Reset
REQ-028 While rst is high: state=IDLE, cnt=0, busy=0, done=0, tc_pulse=0, err_pulse=0, cmd_ready=0, latched limit=0, latched mode=0, prescaler=0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately and asynchronously, and SHALL suppress any pending tc_pulse.

Configuration
REQ-030 With CNT_CTRL_PRESCALE_EN defined, a tick SHALL occur once every PRESC clocks while in RUN, and the prescaler phase SHALL be preserved across PAUSE/RESUME.
REQ-031 Without CNT_CTRL_PRESCALE_EN, a tick SHALL occur on every RUN clock, the prescaler logic SHALL be absent, and PRESC SHALL be ignored.

Structure
REQ-032 Package cnt_ctrl_pkg SHALL hold the cmd_op encodings and the FSM state type.
REQ-033 The prescaler SHALL be the sub-module cnt_ctrl_presc, instantiated only under CNT_CTRL_PRESCALE_EN.

Verification
REQ-034 Reset, then START limit=5 one-shot with no prescaler -> cnt steps 0..5, tc_pulse once when cnt=5, done=1, cnt holds 5.
REQ-035 START limit=3 periodic, run 12 ticks -> tc_pulse at ticks 4, 8 and 12, with cnt sequence 0,1,2,3,0.
REQ-036 PAUSE at cnt=2, wait 10 clocks, then RESUME -> cnt stays 2 in HOLD with busy=1, and counting continues from 3.
REQ-037 PAUSE in IDLE and RESUME in RUN -> err_pulse=1 for one cycle each, with no state change.
REQ-038 STOP on the same cycle as the terminal tick (limit=2) -> no tc_pulse, state=IDLE, cnt=0.
REQ-039 With CNT_CTRL_PRESCALE_EN and PRESC=4, assert rst mid-RUN -> all outputs reach their reset values immediately, and after START cnt increments every 4th clock.
